// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU control decoder: ALUFun codes,
// MIPS opcode/funct values, operand-select encodings and skid-buffer states.
// The per-entry illegal flag exists only when ALU_CTRL_TRAP_ILLEGAL_EN is defined.
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_GEZ = 6'b111001;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] ASEL_RS      = 2'd0;
  localparam logic [1:0] ASEL_SHAMT   = 2'd1;
  localparam logic [1:0] ASEL_CONST16 = 2'd2;

  localparam logic [1:0] BSEL_RT   = 2'd0;
  localparam logic [1:0] BSEL_SEXT = 2'd1;
  localparam logic [1:0] BSEL_ZEXT = 2'd2;
  localparam logic [1:0] BSEL_ZERO = 2'd3;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [5:0] alufun;
    logic       sign;
    logic [1:0] asel;
    logic [1:0] bsel;
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
    logic       illegal;
`endif
  } alu_ctrl_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry in-order valid/ready buffer with registered upstream ready.
// State is exported on state_o; data_o always holds the oldest entry.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output skid_state_e      state_o
);

  // Handshake: a transfer happens on a clock edge where valid and ready are
  // both high; flush_i overrides both transfers in that cycle.
  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_skid_buf: DEPTH must be 2");
  end

  skid_state_e      state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             acc, iss;

  assign acc = valid_i & ready_q;
  assign iss = (state_q != SKID_EMPTY) & ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (acc) begin
            state_d = SKID_ONE;
            head_d  = data_i;
          end
        end
        SKID_ONE: begin
          if (acc && iss) begin
            head_d = data_i;
          end else if (acc) begin
            state_d = SKID_FULL;
            tail_d  = data_i;
          end else if (iss) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (iss) begin
            state_d = SKID_ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    ready_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = head_q;
  assign state_o = state_q;

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Decodes MIPS instructions into ALU controls ahead of a 2-entry skid buffer.
// Define ALU_CTRL_TRAP_ILLEGAL_EN to flag unlisted encodings and count them.
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int         SKID_DEPTH = 2,
  parameter logic [5:0] RST_ALUFUN = 6'b000000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInstr,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iFlush,
  output logic        oValid,
  input  logic        iReady,
  output logic [5:0]  oALUFun,
  output logic        oSign,
  output logic [1:0]  oASel,
  output logic [1:0]  oBSel,
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
  output logic [15:0] oIllegalCnt,
`endif
  output logic        oIllegal
);

  alu_ctrl_t   dec;
  alu_ctrl_t   head;
  skid_state_e skid_state;
  logic [5:0]  opcode, funct;
  logic [4:0]  rt;
  logic        valid;

  assign opcode = iInstr[31:26];
  assign rt     = iInstr[20:16];
  assign funct  = iInstr[5:0];

  always_comb begin
    dec      = '0;
    dec.bsel = BSEL_ZERO;
    case (opcode)
      OP_RTYPE: begin
        dec.bsel = BSEL_RT;
        case (funct)
          FN_ADD:  begin dec.alufun = ALU_ADD; dec.sign = 1'b1; end
          FN_ADDU: dec.alufun = ALU_ADD;
          FN_SUB:  begin dec.alufun = ALU_SUB; dec.sign = 1'b1; end
          FN_SUBU: dec.alufun = ALU_SUB;
          FN_AND:  dec.alufun = ALU_AND;
          FN_OR:   dec.alufun = ALU_OR;
          FN_XOR:  dec.alufun = ALU_XOR;
          FN_NOR:  dec.alufun = ALU_NOR;
          FN_SLT:  begin dec.alufun = ALU_LT; dec.sign = 1'b1; end
          FN_SLTU: dec.alufun = ALU_LT;
          FN_SLL:  begin dec.alufun = ALU_SLL; dec.asel = ASEL_SHAMT; end
          FN_SRL:  begin dec.alufun = ALU_SRL; dec.asel = ASEL_SHAMT; end
          FN_SRA:  begin dec.alufun = ALU_SRA; dec.asel = ASEL_SHAMT; end
          FN_JR:   dec.alufun = ALU_ADD;
          default: begin
            dec.bsel = BSEL_ZERO;
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
          end
        endcase
      end
      OP_ADDI:  begin dec.alufun = ALU_ADD; dec.sign = 1'b1; dec.bsel = BSEL_SEXT; end
      OP_ADDIU: begin dec.alufun = ALU_ADD; dec.bsel = BSEL_SEXT; end
      OP_SLTI:  begin dec.alufun = ALU_LT; dec.sign = 1'b1; dec.bsel = BSEL_SEXT; end
      OP_SLTIU: begin dec.alufun = ALU_LT; dec.bsel = BSEL_SEXT; end
      OP_ANDI:  begin dec.alufun = ALU_AND; dec.bsel = BSEL_ZEXT; end
      // lui is realised as (zext imm) << 16 using the constant A operand.
      OP_LUI: begin
        dec.alufun = ALU_SLL;
        dec.asel   = ASEL_CONST16;
        dec.bsel   = BSEL_ZEXT;
      end
      OP_LW, OP_SW: begin dec.alufun = ALU_ADD; dec.sign = 1'b1; dec.bsel = BSEL_SEXT; end
      OP_BEQ:  begin dec.alufun = ALU_EQ; dec.bsel = BSEL_RT; end
      OP_BNE:  begin dec.alufun = ALU_NEQ; dec.bsel = BSEL_RT; end
      OP_BLEZ: begin dec.alufun = ALU_LEZ; dec.sign = 1'b1; end
      OP_BGTZ: begin dec.alufun = ALU_GTZ; dec.sign = 1'b1; end
      OP_REGIMM: begin
        case (rt)
          5'd0: begin dec.alufun = ALU_LT; dec.sign = 1'b1; end
          5'd1: begin dec.alufun = ALU_GEZ; dec.sign = 1'b1; end
          default: begin
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
          end
        endcase
      end
      default: begin
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  alu_skid_buf #(
    .WIDTH($bits(alu_ctrl_t)),
    .DEPTH(SKID_DEPTH)
  ) u_skid (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .flush_i(iFlush),
    .valid_i(iValid),
    .ready_o(oReady),
    .data_i (dec),
    .ready_i(iReady),
    .data_o (head),
    .state_o(skid_state)
  );

  // Stale buffer contents are masked so idle outputs match the reset values.
  assign valid   = (skid_state != SKID_EMPTY);
  assign oValid  = valid;
  assign oALUFun = valid ? head.alufun : RST_ALUFUN;
  assign oSign   = valid & head.sign;
  assign oASel   = valid ? head.asel : 2'b00;
  assign oBSel   = valid ? head.bsel : 2'b00;

`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
  logic [15:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (iValid && oReady && !iFlush && dec.illegal && (ill_cnt_q != 16'hFFFF)) begin
      ill_cnt_d = ill_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) ill_cnt_q <= '0;
    else      ill_cnt_q <= ill_cnt_d;
  end

  assign oIllegalCnt = ill_cnt_q;
  assign oIllegal    = valid & head.illegal;
`else
  assign oIllegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Scoreboard bench for alu_ctrl_decoder: directed instruction words with
// hand-decoded expected controls, checked by an independent output monitor.
module tb_alu_ctrl_decoder;

  logic        iClk = 1'b0;
  logic        iRst, iValid, iFlush, iReady;
  logic [31:0] iInstr;
  logic        oReady, oValid, oSign, oIllegal;
  logic [5:0]  oALUFun;
  logic [1:0]  oASel, oBSel;
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
  logic [15:0] oIllegalCnt;
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  alu_ctrl_decoder dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iInstr (iInstr),
    .iValid (iValid),
    .oReady (oReady),
    .iFlush (iFlush),
    .oValid (oValid),
    .iReady (iReady),
    .oALUFun(oALUFun),
    .oSign  (oSign),
    .oASel  (oASel),
    .oBSel  (oBSel),
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
    .oIllegalCnt(oIllegalCnt),
`endif
    .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  // Packed view {alufun, sign, asel, bsel, illegal}
  logic [12:0] act;
  assign act = {oALUFun, oSign, oASel, oBSel, oIllegal};

  logic [12:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [12:0] pk(logic [5:0] f, logic s, logic [1:0] a, logic [1:0] b, logic il);
    return {f, s, a, b, il};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input bit expect_issue, input logic [12:0] e);
    int n = 0;
    while (!oReady && n < 50) begin
      tick();
      n++;
    end
    if (!oReady) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: oReady stuck at %b, required 1", oReady);
    end
    iValid = 1'b1;
    iInstr = instr;
    if (expect_issue) exp_q.push_back(e);
    tick();
    iValid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   {31'd0, oValid},   32'd0);
    check({tag, "_ready"},   {31'd0, oReady},   32'd0);
    check({tag, "_alufun"},  {26'd0, oALUFun},  32'd0);
    check({tag, "_sign"},    {31'd0, oSign},    32'd0);
    check({tag, "_asel"},    {30'd0, oASel},    32'd0);
    check({tag, "_bsel"},    {30'd0, oBSel},    32'd0);
    check({tag, "_illegal"}, {31'd0, oIllegal}, 32'd0);
  endtask

  // Monitor: a downstream transfer pops one expected entry.
  always @(negedge iClk) begin
    if (!iRst && !iFlush && oValid && iReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %h with empty queue, required no issue", act);
      end else begin
        check("issue", {19'd0, act}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  localparam logic [12:0] E_ADD  = {6'b000000, 1'b1, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] E_SLT  = {6'b110101, 1'b1, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] E_ANDI = {6'b011000, 1'b0, 2'd0, 2'd2, 1'b0};
  localparam logic [12:0] E_BEQ  = {6'b110011, 1'b0, 2'd0, 2'd0, 1'b0};

  logic [31:0] vec_instr [6];
  logic [12:0] vec_exp   [6];

  initial begin
    int n;
    vec_instr[0] = 32'h3C011234; vec_exp[0] = pk(6'b100000, 1'b0, 2'd2, 2'd2, 1'b0); // lui
    vec_instr[1] = 32'h04210004; vec_exp[1] = pk(6'b111001, 1'b1, 2'd0, 2'd3, 1'b0); // bgez
    vec_instr[2] = 32'h04200004; vec_exp[2] = pk(6'b110101, 1'b1, 2'd0, 2'd3, 1'b0); // bltz
    vec_instr[3] = 32'h00011883; vec_exp[3] = pk(6'b100011, 1'b0, 2'd1, 2'd0, 1'b0); // sra
    vec_instr[4] = 32'hAC220004; vec_exp[4] = pk(6'b000000, 1'b1, 2'd0, 2'd1, 1'b0); // sw
    vec_instr[5] = 32'h14220003; vec_exp[5] = pk(6'b110001, 1'b0, 2'd0, 2'd0, 1'b0); // bne

    iRst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b0; iInstr = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    iRst = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, oReady}, 32'd1);

    // Single word, one-cycle latency, then empty.
    iReady = 1'b1;
    push(32'h00430820, 1'b1, E_ADD);
    check("add_valid", {31'd0, oValid}, 32'd1);
    tick();
    check("add_drained", {31'd0, oValid}, 32'd0);

    // Stall: fill to FULL, outputs hold the oldest entry.
    iReady = 1'b0;
    push(32'h0022082A, 1'b1, E_SLT);
    push(32'h302100FF, 1'b1, E_ANDI);
    check("full_ready", {31'd0, oReady}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {19'd0, act}, {19'd0, E_SLT});
      tick();
    end
    iReady = 1'b1;
    push(32'h10220003, 1'b1, E_BEQ);
    repeat (3) tick();

    for (int i = 0; i < 6; i++) push(vec_instr[i], 1'b1, vec_exp[i]);
    repeat (3) tick();

    // Flush while FULL with iValid and iReady asserted.
    iReady = 1'b0;
    push(32'h00430820, 1'b0, '0);
    push(32'h0022082A, 1'b0, '0);
    check("pre_flush_ready", {31'd0, oReady}, 32'd0);
    check("pre_flush_valid", {31'd0, oValid}, 32'd1);
    iFlush = 1'b1; iValid = 1'b1; iInstr = 32'h00430820; iReady = 1'b1;
    tick();
    iFlush = 1'b0; iValid = 1'b0;
    check("flush_valid", {31'd0, oValid}, 32'd0);
    check("flush_ready", {31'd0, oReady}, 32'd1);
    tick();
    check("flush_nothing", {31'd0, oValid}, 32'd0);

    // Unlisted opcode decodes as the NOP pattern.
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
    check("ill_cnt_0", {16'd0, oIllegalCnt}, 32'd0);
`endif
    push(32'hFC000000, 1'b1, pk(6'b000000, 1'b0, 2'd0, 2'd3, ILL));
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
    check("ill_cnt_1", {16'd0, oIllegalCnt}, 32'd1);
`endif
    repeat (2) tick();

    // Reset with entries buffered.
    iReady = 1'b0;
    push(32'hFC000000, 1'b0, '0);
    push(32'h00430820, 1'b0, '0);
    iRst = 1'b1;
    tick();
    check_reset_outputs("midreset");
`ifdef ALU_CTRL_TRAP_ILLEGAL_EN
    check("ill_cnt_reset", {16'd0, oIllegalCnt}, 32'd0);
`endif
    iRst = 1'b0;
    iReady = 1'b1;
    repeat (2) tick();
    check("post_reset_empty", {31'd0, oValid}, 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
